// File: rtl/pc_sequencer_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : pc_sequencer_if
// Purpose  : Bundle of hazard/decode requests into the next-PC controller and
//            the fetch-stage control it returns.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
interface pc_sequencer_if #(
    parameter int N     = 32,
    parameter int CNT_W = 16
);
    logic             stall_req;
    logic             branch_taken;
    logic [N-1:0]     branch_pc;
    logic [N-1:0]     branch_imm;
    logic [N-1:0]     pc;
    logic             pc_write;
    logic             ifid_write;
    logic             ifid_flush;
    logic [1:0]       state;
    logic             stall_timeout;
    logic [CNT_W-1:0] redirect_count;

    // Pipeline side: raises hazard/branch requests, consumes fetch control
    modport master (
        output stall_req, branch_taken, branch_pc, branch_imm,
        input  pc, pc_write, ifid_write, ifid_flush, state,
               stall_timeout, redirect_count
    );

    // Sequencer side
    modport slave (
        input  stall_req, branch_taken, branch_pc, branch_imm,
        output pc, pc_write, ifid_write, ifid_flush, state,
               stall_timeout, redirect_count
    );
endinterface
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : pc_sequencer
// Purpose  : Fetch-stage next-PC controller. Chooses each cycle between
//            sequential increment, hazard hold and branch redirect, and
//            drives the IF/ID write-enable and flush.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
module pc_sequencer #(
    parameter int          N         = 32,
    parameter int unsigned RESET_PC  = 0,
    parameter int unsigned PC_INC    = 1,
    parameter int          FLUSH_CYC = 1,
    parameter int          MAX_STALL = 15,
    parameter int          CNT_W     = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    pc_sequencer_if.slave  bus
);
    localparam int SC_W = $clog2(MAX_STALL + 1);
    localparam int FC_W = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;

    localparam logic [SC_W-1:0] STALL_MAX  = SC_W'(MAX_STALL);
    localparam logic [FC_W-1:0] FLUSH_LOAD = FC_W'(FLUSH_CYC - 1);
    localparam logic [N-1:0]    PC_STEP    = N'(PC_INC);
    localparam logic [N-1:0]    PC_RST     = N'(RESET_PC);

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_STALL = 2'b01,
        ST_FLUSH = 2'b10
    } state_t;

    state_t           state_q;
    logic [N-1:0]     pc_q;
    logic [SC_W-1:0]  stall_cnt_q;
    logic [FC_W-1:0]  flush_cnt_q;
    logic             stall_timeout_q;
    logic [CNT_W-1:0] redirect_count_q;

    logic             redirect;
    logic             hold;
    logic [SC_W-1:0]  stall_cnt_nxt;
    logic [N-1:0]     target;

    // Same-cycle qualifiers: a branch seen while flushing is on the wrong
    // path, and a redirect always beats a stall request.
    always_comb begin
        redirect      = bus.branch_taken && (state_q != ST_FLUSH);
        hold          = bus.stall_req && !redirect && (state_q != ST_FLUSH);
        target        = bus.branch_pc + bus.branch_imm;
        stall_cnt_nxt = SC_W'(1);
        if (state_q == ST_STALL) begin
            stall_cnt_nxt = (stall_cnt_q == STALL_MAX) ? stall_cnt_q
                                                       : stall_cnt_q + SC_W'(1);
        end
    end

    assign bus.pc             = pc_q;
    assign bus.pc_write       = !hold;
    assign bus.ifid_write     = !hold;
    assign bus.ifid_flush     = (state_q == ST_FLUSH);
    assign bus.state          = state_q;
    assign bus.stall_timeout  = stall_timeout_q;
    assign bus.redirect_count = redirect_count_q;

    // PC register: redirect, then hold, then sequential increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= PC_RST;
        end else if (redirect) begin
            pc_q <= target;
        end else if (!hold) begin
            pc_q <= pc_q + PC_STEP;
        end
    end

    // Control FSM with stall/flush counters and sticky stall timeout
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= ST_RUN;
            stall_cnt_q      <= '0;
            flush_cnt_q      <= '0;
            stall_timeout_q  <= 1'b0;
            redirect_count_q <= '0;
        end else begin
            if (redirect) begin
                state_q          <= ST_FLUSH;
                flush_cnt_q      <= FLUSH_LOAD;
                stall_cnt_q      <= '0;
                redirect_count_q <= redirect_count_q + CNT_W'(1);
            end else begin
                case (state_q)
                    ST_RUN: begin
                        if (hold) begin
                            state_q     <= ST_STALL;
                            stall_cnt_q <= stall_cnt_nxt;
                        end
                    end
                    ST_STALL: begin
                        if (hold) begin
                            stall_cnt_q <= stall_cnt_nxt;
                        end else begin
                            state_q     <= ST_RUN;
                            stall_cnt_q <= '0;
                        end
                    end
                    ST_FLUSH: begin
                        if (flush_cnt_q == '0) begin
                            state_q <= ST_RUN;
                        end else begin
                            flush_cnt_q <= flush_cnt_q - FC_W'(1);
                        end
                    end
                    default: begin
                        state_q     <= ST_RUN;
                        stall_cnt_q <= '0;
                    end
                endcase
            end
            // Timeout latches at the edge the hold count reaches its limit
            if (hold && (stall_cnt_nxt == STALL_MAX)) begin
                stall_timeout_q <= 1'b1;
            end
        end
    end
endmodule
`default_nettype wire
